// File: rtl/keypoint_scan_ctrl.sv
// Scans the interior of a stored 3-level DoG frame, reading each 3x3x3 neighbourhood
// and emitting a record for every centre that is a strict local minimum or maximum.
module keypoint_scan_ctrl #(
  parameter int unsigned N          = 450,
  parameter int unsigned M          = 600,
  parameter int unsigned AW         = 19,
  parameter int unsigned SIGNED_CMP = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [15:0]   rd_data1,
  input  logic [15:0]   rd_data2,
  input  logic [15:0]   rd_data3,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_addr,
  output logic [1:0]    out_type,
  output logic [19:0]   kp_count
);

  localparam int unsigned RW    = $clog2(N);
  localparam int unsigned CW    = $clog2(M);
  localparam int unsigned R_MAX = N - 2;
  localparam int unsigned C_MAX = M - 2;

  typedef enum logic [2:0] {IDLE, FETCH, LAST, EVAL, EMIT, DONE} state_t;

  state_t        state;
  logic [RW-1:0] r, nr;
  logic [CW-1:0] c, nc;
  logic [3:0]    t;
  logic          last_centre;
  logic          is_min, is_max, advance;
  logic          cap_en;
  logic [3:0]    cap_idx;
  logic [15:0]   w1 [9];
  logic [15:0]   w2 [9];
  logic [15:0]   w3 [9];

  function automatic logic less(input logic [15:0] a, input logic [15:0] b);
    if (SIGNED_CMP != 0) return $signed(a) < $signed(b);
    else                 return a < b;
  endfunction

  // Address of read k within the 3x3 window centred on (row, col), row-major.
  function automatic logic [AW-1:0] win_addr(input logic [RW-1:0] row,
                                             input logic [CW-1:0] col,
                                             input logic [3:0]    k);
    int unsigned ri, ci;
    ri = 32'(row) - 32'd1 + 32'(k) / 32'd3;
    ci = 32'(col) - 32'd1 + 32'(k) % 32'd3;
    return AW'(ri * M + ci);
  endfunction

  // Centre sample against the 26 neighbours across the three levels.
  always_comb begin
    is_min = 1'b1;
    is_max = 1'b1;
    for (int unsigned i = 0; i < 9; i++) begin
      if (!less(w2[4], w1[4'(i)])) is_min = 1'b0;
      if (!less(w1[4'(i)], w2[4])) is_max = 1'b0;
      if (!less(w2[4], w3[4'(i)])) is_min = 1'b0;
      if (!less(w3[4'(i)], w2[4])) is_max = 1'b0;
      if (i != 4) begin
        if (!less(w2[4], w2[4'(i)])) is_min = 1'b0;
        if (!less(w2[4'(i)], w2[4])) is_max = 1'b0;
      end
    end
  end

  always_comb begin
    nr          = r;
    nc          = c;
    last_centre = 1'b0;
    if (c < CW'(C_MAX)) begin
      nc = c + CW'(1);
    end else if (r < RW'(R_MAX)) begin
      nc = CW'(1);
      nr = r + RW'(1);
    end else begin
      last_centre = 1'b1;
    end
  end

  assign advance = ((state == EVAL) && !(is_min || is_max)) ||
                   ((state == EMIT) && out_ready);
  assign cap_en  = ((state == FETCH) && (t != 4'd0)) || (state == LAST);
  assign cap_idx = (state == LAST) ? 4'd8 : (t - 4'd1);

  // Read data lags rd_en by one cycle, so capture index trails the fetch counter.
  always_ff @(posedge clk) begin
    if (cap_en) begin
      w1[cap_idx] <= rd_data1;
      w2[cap_idx] <= rd_data2;
      w3[cap_idx] <= rd_data3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_en     <= 1'b0;
      rd_addr   <= '0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_type  <= 2'b00;
      kp_count  <= '0;
      r         <= RW'(1);
      c         <= CW'(1);
      t         <= 4'd0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: if (start) begin
          r        <= RW'(1);
          c        <= CW'(1);
          t        <= 4'd0;
          kp_count <= '0;
          busy     <= 1'b1;
          rd_en    <= 1'b1;
          rd_addr  <= win_addr(RW'(1), CW'(1), 4'd0);
          state    <= FETCH;
        end
        FETCH: begin
          if (t == 4'd8) begin
            rd_en <= 1'b0;
            state <= LAST;
          end else begin
            t       <= t + 4'd1;
            rd_addr <= win_addr(r, c, t + 4'd1);
          end
        end
        LAST: state <= EVAL;
        EVAL: if (is_min || is_max) begin
          state     <= EMIT;
          out_valid <= 1'b1;
          out_addr  <= AW'(32'(r) * M + 32'(c));
          out_type  <= is_min ? 2'b01 : 2'b10;
        end
        EMIT: if (out_ready) begin
          out_valid <= 1'b0;
          if (kp_count != '1) kp_count <= kp_count + 20'd1;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
      // Step to the next interior centre, or finish after the last one.
      if (advance) begin
        if (last_centre) begin
          state <= DONE;
          done  <= 1'b1;
          busy  <= 1'b0;
        end else begin
          r       <= nr;
          c       <= nc;
          t       <= 4'd0;
          rd_en   <= 1'b1;
          rd_addr <= win_addr(nr, nc, 4'd0);
          state   <= FETCH;
        end
      end
    end
  end

endmodule

// File: tb/tb_keypoint_scan_ctrl.sv
// Scoreboard bench for keypoint_scan_ctrl on a 5x5 frame: a reference model predicts
// the records and read-address order, an independent monitor checks the DUT against them.
module tb_keypoint_scan_ctrl;
  localparam int N  = 5;
  localparam int M  = 5;
  localparam int AW = 5;
  localparam int NREADS = (N - 2) * (M - 2) * 9;

  logic          clk = 1'b0;
  logic          rst_n, start, out_ready;
  logic          busy, done, rd_en, out_valid;
  logic [AW-1:0] rd_addr, out_addr;
  logic [15:0]   rd_data1, rd_data2, rd_data3;
  logic [1:0]    out_type;
  logic [19:0]   kp_count;

  logic [15:0] mem1 [N*M];
  logic [15:0] mem2 [N*M];
  logic [15:0] mem3 [N*M];

  int checks = 0;
  int failures = 0;
  int exp_addr_q [$];
  int exp_type_q [$];
  int exp_kp;
  int rd_idx, valid_cycles, done_cnt;
  logic          prev_stall = 1'b0;
  logic [AW-1:0] prev_addr;
  logic [1:0]    prev_type;

  keypoint_scan_ctrl #(.N(N), .M(M), .AW(AW), .SIGNED_CMP(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data1(rd_data1), .rd_data2(rd_data2),
    .rd_data3(rd_data3), .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_type(out_type), .kp_count(kp_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rd_en) begin
      rd_data1 <= mem1[rd_addr];
      rd_data2 <= mem2[rd_addr];
      rd_data3 <= mem3[rd_addr];
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Read n of a full scan: centres in raster order, nine reads per 3x3 window.
  function automatic int exp_rd(input int n);
    int centre, k, r, c;
    centre = n / 9;
    k = n % 9;
    r = 1 + centre / (M - 2);
    c = 1 + centre % (M - 2);
    return (r - 1 + k / 3) * M + (c - 1 + k % 3);
  endfunction

  function automatic int val(input int lvl, input int a);
    if (lvl == 1) return int'(mem1[a]);
    if (lvl == 2) return int'(mem2[a]);
    return int'(mem3[a]);
  endfunction

  task automatic build_expected();
    int ctr, v;
    bit mn, mx;
    exp_addr_q.delete();
    exp_type_q.delete();
    exp_kp = 0;
    for (int r = 1; r <= N - 2; r++)
      for (int c = 1; c <= M - 2; c++) begin
        ctr = val(2, r * M + c);
        mn = 1'b1;
        mx = 1'b1;
        for (int lvl = 1; lvl <= 3; lvl++)
          for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++)
              if (!(lvl == 2 && dr == 0 && dc == 0)) begin
                v = val(lvl, (r + dr) * M + c + dc);
                if (ctr >= v) mn = 1'b0;
                if (ctr <= v) mx = 1'b0;
              end
        if (mn || mx) begin
          exp_addr_q.push_back(r * M + c);
          exp_type_q.push_back(mn ? 1 : 2);
          exp_kp++;
        end
      end
  endtask

  // Monitor: read order, record hold during stalls, and record contents on accept.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rd_en) begin
        check("rd_addr", longint'(rd_addr), longint'(exp_rd(rd_idx)));
        rd_idx++;
      end
      if (prev_stall)
        check("emit_hold", longint'({out_valid, out_addr, out_type}),
              longint'({1'b1, prev_addr, prev_type}));
      if (out_valid) valid_cycles++;
      if (out_valid && out_ready) begin
        if (exp_addr_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_record actual addr=%0d type=%0d required none", out_addr, out_type);
        end else begin
          check("out_addr", longint'(out_addr), longint'(exp_addr_q.pop_front()));
          check("out_type", longint'(out_type), longint'(exp_type_q.pop_front()));
        end
      end
      if (done) done_cnt++;
      prev_stall = out_valid && !out_ready;
      prev_addr  = out_addr;
      prev_type  = out_type;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic fill(input int v);
    for (int a = 0; a < N * M; a++) begin
      mem1[a] = 16'(v);
      mem2[a] = 16'(v);
      mem3[a] = 16'(v);
    end
  endtask

  // mode 0: always ready; 1: random ready plus stray start pulses; 2: stall 7 cycles.
  task automatic run_scan(input int mode, output int fetch_to_done);
    int cyc, stall;
    bit got;
    build_expected();
    rd_idx = 0;
    valid_cycles = 0;
    done_cnt = 0;
    cyc = 0;
    stall = 0;
    got = 1'b0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    while (cyc < 3000) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      if (out_valid) stall++;
      if (mode == 0)      out_ready = 1'b1;
      else if (mode == 1) out_ready = ($urandom % 3) != 0;
      else                out_ready = (stall >= 8);
      start = busy && (mode == 1) && (($urandom % 16) == 0);
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    out_ready = 1'b1;
    fetch_to_done = cyc;
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL scan_timeout actual=no done required done within 3000 cycles");
    end
    @(posedge clk); #1;
    check("done_single", longint'(done), 0);
    check("done_count", done_cnt, 1);
    check("kp_count", longint'(kp_count), exp_kp);
    check("records_left", exp_addr_q.size(), 0);
    check("reads_total", rd_idx, NREADS);
    check("busy_after", longint'(busy), 0);
  endtask

  initial begin
    int lat, idle_bad, cr, cc;
    rst_n = 1'b0;
    start = 1'b0;
    out_ready = 1'b1;
    fill(0);
    #23;
    check("reset_outputs", longint'({busy, done, rd_en, out_valid, rd_addr, out_addr, out_type, kp_count}), 0);
    #4 rst_n = 1'b1;
    idle_bad = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (busy || rd_en || out_valid || done) idle_bad = 1;
    end
    check("idle_after_release", idle_bad, 0);

    // All-zero frame: no records, fixed latency.
    run_scan(0, lat);
    check("zero_latency", lat, 99);

    // Single minimum at the middle centre.
    fill(100);
    mem2[12] = 16'd5;
    run_scan(0, lat);
    check("min_latency", lat, 100);

    // Single maximum with a 7-cycle consumer stall.
    mem2[12] = 16'd200;
    run_scan(2, lat);
    check("stall_valid_cycles", valid_cycles, 8);

    // Tie with one level-3 neighbour suppresses the record.
    mem2[12] = 16'd5;
    mem3[18] = 16'd5;
    run_scan(0, lat);
    check("tie_latency", lat, 99);

    // Asynchronous reset in the middle of a fetch.
    fill(0);
    build_expected();
    rd_idx = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check("midfetch_reset", longint'({busy, done, rd_en, out_valid, rd_addr, out_addr, out_type, kp_count}), 0);
    #2 rst_n = 1'b1;
    idle_bad = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (busy || rd_en || out_valid || done) idle_bad = 1;
    end
    check("idle_after_midreset", idle_bad, 0);
    run_scan(0, lat);
    check("rescan_latency", lat, 99);

    // Random frames, random back-pressure, stray start pulses while busy.
    for (int k = 0; k < 6; k++) begin
      for (int a = 0; a < N * M; a++) begin
        mem1[a] = 16'($urandom_range(1, 14));
        mem2[a] = 16'($urandom_range(1, 14));
        mem3[a] = 16'($urandom_range(1, 14));
      end
      cr = $urandom_range(1, N - 2);
      cc = $urandom_range(1, M - 2);
      mem2[cr * M + cc] = (($urandom % 2) == 0) ? 16'h0000 : 16'hFFFF;
      run_scan(1, lat);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/keypoint_scan_ctrl.md
KEYPOINT_SCAN_CTRL -- requirements
Module: keypoint_scan_ctrl

Interface
REQ-001 Parameters (name, default, meaning):
- N, 450: image rows (N >= 3).
- M, 600: image columns (M >= 3).
- AW, 19: read-address width (2^AW >= N*M).
- SIGNED_CMP, 0: 1 = compare samples as two's complement; 0 = unsigned.
REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1: clock; all logic on rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- start, in, 1: begin a scan of the stored frame.
- busy, out, 1: scan in progress.
- done, out, 1: one-cycle pulse at scan end.
- rd_en, out, 1: read strobe to the three DoG frame buffers.
- rd_addr, out, AW: shared read address, row-major, addr = row*M + col.
- rd_data1, in, 16: DoG level 1 sample, valid the cycle after rd_en.
- rd_data2, in, 16: DoG level 2 (centre level) sample, same timing.
- rd_data3, in, 16: DoG level 3 sample, same timing.
- out_valid, out, 1: keypoint record available.
- out_ready, in, 1: consumer accepts the record.
- out_addr, out, AW: centre-pixel address r*M + c.
- out_type, out, 2: 2'b01 = minimum, 2'b10 = maximum.
- kp_count, out, 20: keypoints emitted in the current or last scan, saturating at 2^20-1.
REQ-003 Clock is clk; reset is rst_n, asynchronous assert, active low. These are fixed.

Function
REQ-004 States: IDLE, FETCH, LAST, EVAL, EMIT, DONE.
REQ-005 IDLE: start=1 sets r=1, c=1, kp_count=0 and moves to FETCH. start is ignored in every other state.
REQ-006 busy is 1 in FETCH, LAST, EVAL and EMIT, and 0 otherwise.
REQ-007 FETCH lasts 9 cycles, t=0..8, with rd_en=1 and rd_addr=(r-1+t/3)*M + (c-1+t%3), so p-major order.
REQ-008 The sample returned for read t is captured the following cycle into w1[t], w2[t] and w3[t].
REQ-009 LAST: one cycle, rd_en=0, captures t=8 and moves to EVAL.
REQ-010 EVAL: one cycle. The centre w2[4] is compared against the other 26 window samples (all 9 of w1, all 9 of w3, w2 excluding index 4).
- Strictly less than all 26: minimum.
- Strictly greater than all 26: maximum.
- Any equality: neither.
REQ-011 EVAL with an extremum moves to EMIT with out_valid=1 and out_addr/out_type registered. Otherwise it advances the centre directly.
REQ-012 EMIT holds out_valid, out_addr and out_type stable until out_valid&&out_ready. On that cycle kp_count increments (saturating) and the centre advances. out_valid falls the next cycle.
REQ-013 Advance rule:
- If c < M-2: c = c+1.
- Else if r < N-2: c = 1, r = r+1, next state FETCH.
- Else (r = N-2, c = M-2): next state DONE.
REQ-014 Latency: 11 cycles per non-keypoint centre. A keypoint centre takes 11 cycles plus 1 per EMIT cycle.
REQ-015 DONE: done=1 for exactly one cycle, then IDLE. kp_count holds its value until the next start.
REQ-016 Border pixels (row 0, row N-1, col 0, col M-1) are never centres. rd_addr never exceeds N*M-1.
REQ-017 out_valid=0 and rd_en=0 in IDLE, LAST, EVAL and DONE.

Reset
REQ-018 rst_n=0 at any time, including mid-FETCH or mid-EMIT, immediately forces:
- state IDLE.
- busy, done, rd_en, out_valid = 0.
- rd_addr, out_addr, out_type, kp_count = 0.
- r = 1, c = 1.
- Window registers need not be reset.
REQ-019 After reset release, no read or output activity occurs until start is sampled high.

Verification (N=5, M=5)
REQ-020 All-zero frame, start pulse:
- 9 centres, no out_valid.
- done pulses 99 cycles after FETCH entry.
- kp_count=0.
REQ-021 Address order, first window (r=1, c=1): rd_addr sequence is 0,1,2,5,6,7,10,11,12. Second window starts at 1.
REQ-022 Frame of all 100 with level-2 addr 12 = 5:
- Exactly one record: out_addr=12, out_type=01.
- kp_count=1.
REQ-023 Same frame with level-2 addr 12 = 200 and out_ready held 0 for 7 cycles:
- out_valid stays high with out_addr=12, out_type=10 for 8 cycles.
- The accept then occurs and the scan resumes at c=3.
REQ-024 Tie: centre 5 and one level-3 neighbour 5, all others 100 -> no record emitted.
REQ-025 Reset and start gating:
- rst_n pulsed low during FETCH t=4 -> all outputs 0 immediately. A subsequent start rescans from address 0.
- start asserted while busy has no effect.
